uart_rx_bit_sampler: RTL and testbench
======================================

UART_RX_BIT_SAMPLER -- requirements
Module: uart_rx_bit_sampler

Interface
REQ-001 Parameter PWIDTH, 6: width of prescale and of the internal edge counter.
REQ-002 Parameter SYNC_STAGES, 2: number of rx_in synchronizer flops; legal range 2..4.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  sampling enable; high = bit-period counting active.
REQ-006 resync  input  1  restart bit period (driven on detected start edge); overrides enable.
REQ-007 prescale  input  PWIDTH  oversampling ratio, clocks per bit.
REQ-008 sample_mode  input  2  00 = 1 vote; 01 = 3 votes; 10 = 5 votes; 11 = 3 votes (reserved alias).
REQ-009 rx_in  input  1  asynchronous serial line.
REQ-010 sampled_bit  output  1  majority-vote result of the last completed bit period.
REQ-011 bit_valid  output  1  one-cycle pulse; sampled_bit and noise_flag are updated.
REQ-012 noise_flag  output  1  votes of the last bit were not unanimous.
REQ-013 cfg_err  output  1  prescale illegal (< 8); combinational from prescale.

Function
REQ-014 rx_in SHALL pass through SYNC_STAGES flops; rx_s (last stage) is the only line value used for voting.
REQ-015 Edge counter ec SHALL count 0..P-1, incrementing each clock while enable=1, resync=0, cfg_err=0, then wrap to 0.
REQ-016 P SHALL be prescale captured into a shadow register whenever ec=0 and counting; prescale changes mid-bit take effect next bit.
REQ-017 Mid point SHALL be M = P>>1; vote window = ec in [M-k, M+k], k = 0/1/2 for 1/3/5 votes.
REQ-018 In each window cycle, a 3-bit ones counter SHALL increment if rx_s=1, and a 3-bit vote counter SHALL increment unconditionally.
REQ-019 At the clock where ec=P-1, the block SHALL register sampled_bit = (2*ones > votes), noise_flag = (ones != 0 and ones != votes), bit_valid = 1; outputs visible the following cycle.
REQ-020 bit_valid SHALL be 0 in every other cycle; it never asserts for two consecutive cycles.
REQ-021 ones and votes SHALL clear on the same edge that registers the result.
REQ-022 sample_mode SHALL be captured with prescale at ec=0; changing it mid-bit SHALL not alter the current window.
REQ-023 resync=1: ec <= 0, ones/votes <= 0, bit_valid <= 0, sampled_bit/noise_flag held; enable is ignored.
REQ-024 enable=0 (resync=0): ec, ones, votes held at 0; bit_valid 0; sampled_bit/noise_flag held.
REQ-025 cfg_err=1: counting suppressed as for enable=0; no bit_valid is ever produced.
REQ-026 Resync asserted on the same edge that ec=P-1 SHALL win: no bit_valid, counters cleared.
REQ-027 No arithmetic SHALL overflow: ec compared against P-1 in PWIDTH bits; window bounds are non-negative for all P >= 8.

Reset
REQ-028 rst=0 SHALL asynchronously clear ec, ones, votes, shadow P/mode, bit_valid, noise_flag to 0; sampled_bit to 1 (line idle); synchronizer flops to 1.
REQ-029 Reset asserted mid-bit SHALL discard partial votes; first bit_valid after release requires a full P-cycle period.

Verification
REQ-030 prescale=16, mode=01, enable=1, rx_s constantly 1 -> bit_valid every 16 clocks, sampled_bit=1, noise_flag=0.
REQ-031 prescale=16, mode=01, rx_s=0 only at ec=8 -> sampled_bit=1, noise_flag=1; same with rx_s=0 at ec=7,8 -> sampled_bit=0, noise_flag=1.
REQ-032 prescale=16, mode=10, rx_s=0 at ec=6 and 10, else 1 -> sampled_bit=1, noise_flag=1; rx_s=0 at ec=6..10 -> sampled_bit=0, noise_flag=0.
REQ-033 prescale=4 with enable=1 for 64 clocks -> cfg_err=1, bit_valid never asserted, sampled_bit stays 1.
REQ-034 prescale=16, resync pulse at ec=12, then rx_s=0 -> next bit_valid exactly 16 clocks after resync, sampled_bit=0; resync at ec=15 -> no bit_valid that period.
REQ-035 rst pulsed low at ec=9, then released -> outputs at reset values immediately; first bit_valid exactly 16 enabled clocks after release.

Source files
------------

// File: rtl/uart_rx_bit_sampler.sv
// rtl/uart_rx_bit_sampler.sv - oversampled UART RX bit sampler with majority voting
module uart_rx_bit_sampler #(
    parameter int PWIDTH      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              resync,
    input  logic [PWIDTH-1:0] prescale,
    input  logic [1:0]        sample_mode,
    input  logic              rx_in,
    output logic              sampled_bit,
    output logic              bit_valid,
    output logic              noise_flag,
    output logic              cfg_err
);

    localparam logic [PWIDTH-1:0] P_MIN = PWIDTH'(8);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic [PWIDTH-1:0]      ec;
    logic [PWIDTH-1:0]      p_sh;
    logic [1:0]             mode_sh;
    logic [2:0]             ones;
    logic [2:0]             votes;

    logic                   counting;
    logic [PWIDTH-1:0]      p_eff;
    logic [1:0]             mode_eff;
    logic [PWIDTH-1:0]      half;
    logic [PWIDTH-1:0]      k;
    logic [PWIDTH-1:0]      win_lo;
    logic [PWIDTH-1:0]      win_hi;
    logic                   in_win;
    logic                   at_end;

    assign rx_s    = sync[SYNC_STAGES-1];
    assign cfg_err = (prescale < P_MIN);

    // At ec=0 the shadow is being loaded this edge, so the live inputs are
    // the values that govern the bit starting now.
    always_comb begin
        counting = enable & ~resync & ~cfg_err;
        p_eff    = (ec == '0) ? prescale : p_sh;
        mode_eff = (ec == '0) ? sample_mode : mode_sh;
        half     = p_eff >> 1;
        case (mode_eff)
            2'b00:   k = PWIDTH'(0);
            2'b10:   k = PWIDTH'(2);
            default: k = PWIDTH'(1);
        endcase
        win_lo   = half - k;
        win_hi   = half + k;
        in_win   = (ec >= win_lo) && (ec <= win_hi);
        at_end   = (ec == (p_eff - PWIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync        <= '1;
            ec          <= '0;
            p_sh        <= '0;
            mode_sh     <= '0;
            ones        <= '0;
            votes       <= '0;
            bit_valid   <= 1'b0;
            noise_flag  <= 1'b0;
            sampled_bit <= 1'b1;
        end else begin
            if (SYNC_STAGES > 1)
                sync <= {sync[SYNC_STAGES-2:0], rx_in};
            else
                sync <= rx_in;
            bit_valid <= 1'b0;
            if (counting) begin
                if (ec == '0) begin
                    p_sh    <= prescale;
                    mode_sh <= sample_mode;
                end
                if (at_end) begin
                    ec          <= '0;
                    ones        <= '0;
                    votes       <= '0;
                    sampled_bit <= ({ones, 1'b0} > {1'b0, votes});
                    noise_flag  <= (ones != 3'd0) && (ones != votes);
                    bit_valid   <= 1'b1;
                end else begin
                    ec <= ec + PWIDTH'(1);
                    if (in_win) begin
                        votes <= votes + 3'd1;
                        ones  <= ones + {2'b00, rx_s};
                    end
                end
            end else begin
                ec    <= '0;
                ones  <= '0;
                votes <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// tb/tb_uart_rx_bit_sampler.sv - scoreboard bench for uart_rx_bit_sampler
module tb_uart_rx_bit_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       resync;
    logic [5:0] prescale;
    logic [1:0] sample_mode;
    logic       rx_in;
    logic       sampled_bit;
    logic       bit_valid;
    logic       noise_flag;
    logic       cfg_err;

    typedef struct {
        logic b;
        logic n;
        int   c;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_bv  = 1'b0;

    uart_rx_bit_sampler #(.PWIDTH(6), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .resync      (resync),
        .prescale    (prescale),
        .sample_mode (sample_mode),
        .rx_in       (rx_in),
        .sampled_bit (sampled_bit),
        .bit_valid   (bit_valid),
        .noise_flag  (noise_flag),
        .cfg_err     (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every bit_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bit_valid) begin
            if (prev_bv) begin
                checks++;
                failures++;
                $display("FAIL consecutive_bit_valid actual=1 expected=0 cycle=%0d", cyc);
            end
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_bit_valid actual=1 expected=0 cycle=%0d", cyc);
            end else begin
                e = sb.pop_front();
                chk("sampled_bit", int'(sampled_bit), int'(e.b));
                chk("noise_flag", int'(noise_flag), int'(e.n));
                chk("bit_valid_cycle", cyc, e.c);
            end
        end
        prev_bv <= rst & bit_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int n, input logic rx);
        rx_in = rx;
        repeat (n) step();
    endtask

    // Step i is the edge at which ec=i; the two-flop synchronizer means
    // rx_in driven before step i is voted at ec=i+2.
    task automatic drive_bit(input logic [15:0] pat, input int len,
                             input logic eb, input logic en, input int mid_step,
                             input logic [5:0] mid_p, input logic [1:0] mid_m);
        exp_t e;
        e.b = eb;
        e.n = en;
        e.c = cyc + len;
        sb.push_back(e);
        for (int i = 0; i < len; i++) begin
            if (i == mid_step) begin
                prescale    = mid_p;
                sample_mode = mid_m;
            end
            rx_in = (i + 2 < len) ? pat[i+2] : 1'b1;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        enable      = 1'b0;
        resync      = 1'b0;
        prescale    = 6'd16;
        sample_mode = 2'b01;
        rx_in       = 1'b1;
        repeat (3) step();
        chk("reset_sampled_bit", int'(sampled_bit), 1);
        chk("reset_bit_valid", int'(bit_valid), 0);
        chk("reset_noise_flag", int'(noise_flag), 0);
        rst = 1'b1;
        step();

        // Illegal prescale: no counting, no pulses.
        prescale = 6'd4;
        #1;
        chk("cfg_err_p4", int'(cfg_err), 1);
        enable = 1'b1;
        run_steps(64, 1'b0);
        chk("cfg_err_sampled_bit", int'(sampled_bit), 1);
        enable   = 1'b0;
        prescale = 6'd16;
        #1;
        chk("cfg_err_p16", int'(cfg_err), 0);
        run_steps(3, 1'b1);

        // Clean idle line, 3 votes, periodic pulses.
        enable = 1'b1;
        drive_bit(16'hFFFF, 16, 1'b1, 1'b0, -1, 6'd0, 2'b00);
        drive_bit(16'hFFFF, 16, 1'b1, 1'b0, -1, 6'd0, 2'b00);
        drive_bit(16'hFEFF, 16, 1'b1, 1'b1, -1, 6'd0, 2'b00);
        drive_bit(16'hFE7F, 16, 1'b0, 1'b1, -1, 6'd0, 2'b00);

        // 5 votes
        sample_mode = 2'b10;
        drive_bit(16'hFBBF, 16, 1'b1, 1'b1, -1, 6'd0, 2'b00);
        drive_bit(16'hF83F, 16, 1'b0, 1'b0, -1, 6'd0, 2'b00);

        // 1 vote, then the reserved 3-vote alias
        sample_mode = 2'b00;
        drive_bit(16'hFEFF, 16, 1'b0, 1'b0, -1, 6'd0, 2'b00);
        drive_bit(16'hFF7F, 16, 1'b1, 1'b0, -1, 6'd0, 2'b00);
        sample_mode = 2'b11;
        drive_bit(16'hFE7F, 16, 1'b0, 1'b1, -1, 6'd0, 2'b00);

        // Mid-bit config change applies only to the following bit.
        sample_mode = 2'b01;
        drive_bit(16'hFE7F, 16, 1'b0, 1'b1, 4, 6'd8, 2'b10);
        drive_bit(16'hFFFB, 8, 1'b1, 1'b1, -1, 6'd0, 2'b00);
        prescale    = 6'd16;
        sample_mode = 2'b01;

        // Resync at ec=12 restarts the period.
        run_steps(12, 1'b1);
        resync = 1'b1;
        step();
        resync = 1'b0;
        drive_bit(16'h0000, 16, 1'b0, 1'b0, -1, 6'd0, 2'b00);

        // Resync at ec=15 suppresses that bit.
        run_steps(15, 1'b1);
        resync = 1'b1;
        step();
        chk("resync_at_end_no_valid", int'(bit_valid), 0);
        resync = 1'b0;

        // Reset mid-bit with partial low votes accumulated.
        drive_bit(16'hFE7F, 16, 1'b0, 1'b1, -1, 6'd0, 2'b00);
        run_steps(9, 1'b0);
        rst   = 1'b0;
        rx_in = 1'b1;
        #1;
        chk("midreset_sampled_bit", int'(sampled_bit), 1);
        chk("midreset_bit_valid", int'(bit_valid), 0);
        chk("midreset_noise_flag", int'(noise_flag), 0);
        step();
        rst = 1'b1;
        drive_bit(16'hFFFF, 16, 1'b1, 1'b0, -1, 6'd0, 2'b00);

        enable = 1'b0;
        run_steps(4, 1'b1);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
